// File: rtl/hmac_sha256_seq.sv
// HMAC-SHA256 sequencer: hashes an over-long key first if needed, then runs the
// inner and outer hashes by building every padded 512-bit block internally and
// driving a single external SHA-256 compression core through cmp_start/cmp_done.
module hmac_sha256_seq #(
  parameter int KEY_BYTES = 80,
  parameter int MSG_BYTES = 84
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [MSG_BYTES*8-1:0] msg,
  output logic                   busy,
  output logic [255:0]           hash,
  output logic                   hash_done,
  output logic                   cmp_start,
  output logic [255:0]           cmp_state_in,
  output logic [511:0]           cmp_block,
  input  logic                   cmp_done,
  input  logic [255:0]           cmp_digest
);

  localparam int NK = (KEY_BYTES + 9 + 63) / 64;
  localparam int NI = (MSG_BYTES + 9 + 63) / 64;
  localparam bit HASH_KEY = (KEY_BYTES > 64);
  localparam logic [4:0] KEY_LAST = 5'(NK - 1);
  localparam logic [4:0] IN_LAST = 5'(NI);
  localparam logic [63:0] MSG_BITS = 64'((64 + MSG_BYTES) * 8);
  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] KEY_ISSUE = 3'd1;
  localparam logic [2:0] KEY_WAIT  = 3'd2;
  localparam logic [2:0] IN_ISSUE  = 3'd3;
  localparam logic [2:0] IN_WAIT   = 3'd4;
  localparam logic [2:0] OUT_ISSUE = 3'd5;
  localparam logic [2:0] OUT_WAIT  = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]        state;
  logic [4:0]        blk_idx;
  logic [255:0]      chain;
  logic [255:0]      inner_digest;
  logic [511:0]      k0;
  logic [511:0]      k0_load;
  logic [511:0]      key_block;
  logic [511:0]      msg_block;
  logic [NI*512-1:0] msg_pad;

  // Inner message padded with the bit length of (K0^ipad || msg); block 0 is in the MSBs
  always_comb begin
    msg_pad = '0;
    msg_pad[NI*512-1 -: MSG_BYTES*8] = msg;
    msg_pad[NI*512-MSG_BYTES*8-1 -: 8] = 8'h80;
    msg_pad[63:0] = MSG_BITS;
  end

  // Inner-phase message block for blk_idx 1..NI (index 0 is the K0^ipad block)
  always_comb begin
    msg_block = '0;
    for (int i = 0; i < NI; i++) begin
      if (blk_idx == 5'(i + 1)) msg_block = msg_pad[(NI-1-i)*512 +: 512];
    end
  end

  generate
    if (HASH_KEY) begin : g_key_hash
      localparam logic [63:0] KEY_BITS = 64'(KEY_BYTES * 8);
      logic [NK*512-1:0] key_pad;

      // Over-long key padded as an ordinary SHA-256 message
      always_comb begin
        key_pad = '0;
        key_pad[NK*512-1 -: KEY_BYTES*8] = key;
        key_pad[NK*512-KEY_BYTES*8-1 -: 8] = 8'h80;
        key_pad[63:0] = KEY_BITS;
      end

      // Key-phase block selected by blk_idx
      always_comb begin
        key_block = '0;
        for (int i = 0; i < NK; i++) begin
          if (blk_idx == 5'(i)) key_block = key_pad[(NK-1-i)*512 +: 512];
        end
      end

      assign k0_load = '0;
    end else begin : g_key_direct
      assign key_block = '0;

      // Short key is used directly, zero-padded to a full block
      always_comb begin
        k0_load = '0;
        k0_load[511 -: KEY_BYTES*8] = key;
      end
    end
  endgenerate

  assign busy         = (state != IDLE);
  assign hash_done    = (state == DONE);
  assign cmp_start    = (state == KEY_ISSUE) || (state == IN_ISSUE) || (state == OUT_ISSUE);
  assign cmp_state_in = (state == IDLE || state == DONE) ? '0 : chain;

  // Block presented to the core, held steady from ISSUE through the matching WAIT
  always_comb begin
    cmp_block = '0;
    case (state)
      KEY_ISSUE, KEY_WAIT: cmp_block = key_block;
      IN_ISSUE, IN_WAIT:   cmp_block = (blk_idx == 5'd0) ? (k0 ^ {64{8'h36}}) : msg_block;
      OUT_ISSUE, OUT_WAIT: cmp_block = (blk_idx == 5'd0) ? (k0 ^ {64{8'h5c}}) :
                                       {inner_digest, 8'h80, 184'd0, 64'd768};
      default:             cmp_block = '0;
    endcase
  end

  // Phase sequencer: issue a block, wait for the core, chain its digest onward
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      blk_idx      <= '0;
      chain        <= '0;
      k0           <= '0;
      inner_digest <= '0;
      hash         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            chain   <= SHA_IV;
            blk_idx <= '0;
            k0      <= k0_load;
            state   <= HASH_KEY ? KEY_ISSUE : IN_ISSUE;
          end
        end
        KEY_ISSUE: state <= KEY_WAIT;
        KEY_WAIT: begin
          if (cmp_done) begin
            if (blk_idx == KEY_LAST) begin
              k0      <= {cmp_digest, 256'd0};
              chain   <= SHA_IV;
              blk_idx <= '0;
              state   <= IN_ISSUE;
            end else begin
              chain   <= cmp_digest;
              blk_idx <= blk_idx + 5'd1;
              state   <= KEY_ISSUE;
            end
          end
        end
        IN_ISSUE: state <= IN_WAIT;
        IN_WAIT: begin
          if (cmp_done) begin
            if (blk_idx == IN_LAST) begin
              inner_digest <= cmp_digest;
              chain        <= SHA_IV;
              blk_idx      <= '0;
              state        <= OUT_ISSUE;
            end else begin
              chain   <= cmp_digest;
              blk_idx <= blk_idx + 5'd1;
              state   <= IN_ISSUE;
            end
          end
        end
        OUT_ISSUE: state <= OUT_WAIT;
        OUT_WAIT: begin
          if (cmp_done) begin
            if (blk_idx == 5'd1) begin
              hash  <= cmp_digest;
              state <= DONE;
            end else begin
              chain   <= cmp_digest;
              blk_idx <= blk_idx + 5'd1;
              state   <= OUT_ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
